pal_se_nbits: RTL and testbench
===============================

PAL_SE_NBITS -- requirements
Module: pal_se_nbits

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of data bits per frame (legal 2..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1, bit order (1 = in[WIDTH-1] first, 0 = in[0] first).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port load, input, 1, capture `in` and start a frame at this edge.
REQ-006 SHALL have port in, input, WIDTH, parallel data word.
REQ-007 SHALL have port shift_en, input, 1, advance serial stream when 1; stall when 0.
REQ-008 SHALL have port out, output, 1, registered serial data bit.
REQ-009 SHALL have port out_valid, output, 1, high while `out` carries a frame bit.
REQ-010 SHALL have port busy, output, 1, high from the first bit through the last bit of a frame.
REQ-011 SHALL have port done, output, 1, one-cycle pulse coincident with the last bit of a frame.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and PAR (PAR only when PARITY_EN is defined).
REQ-013 SHALL, on a rising edge with load=1, capture `in`, enter SHIFT, and drive the first bit on `out` with out_valid=1 and busy=1 in the following cycle (latency 1).
REQ-014 SHALL, in SHIFT with shift_en=1, present the next bit in bit order each cycle, with WIDTH bits per frame.
REQ-015 SHALL, with shift_en=0 and load=0, hold `out`, the bit counter and the state unchanged.
REQ-016 SHALL give load priority over shift_en and over an in-progress frame: a mid-frame load discards remaining bits and restarts with the new word, and done SHALL NOT pulse for the aborted frame.
REQ-017 SHALL assert done in the cycle the last bit is on `out`; the next cycle SHALL return to IDLE unless load=1 at that edge, in which case the new frame's first bit follows with no gap.
REQ-018 SHALL, in IDLE, drive out=0, out_valid=0, busy=0, done=0.
REQ-019 SHALL use a bit counter of width $clog2(WIDTH+1), counting from WIDTH down to 1, with no wrap past zero.
REQ-020 SHALL ignore `in` on any edge where load=0.

Reset
REQ-021 SHALL, when reset=1 at a rising edge, force IDLE, out=0, out_valid=0, busy=0, done=0, counter=0, and clear the shift register, overriding load.
REQ-022 SHALL, when reset is asserted mid-frame, abort the frame with no done pulse; the first edge with reset=0 and load=1 starts a normal frame.

Configuration
REQ-023 SHALL use the macro PAL_SE_PARITY_EN.
REQ-024 SHALL, when PAL_SE_PARITY_EN is defined, append one even-parity bit (XOR of the captured word) after the data bits in state PAR; out_valid and busy stay high, done pulses on the parity bit rather than the last data bit, and shift_en stalls PAR as in REQ-015.
REQ-025 SHALL, when PAL_SE_PARITY_EN is undefined, omit the PAR state and the parity logic entirely, making a frame exactly WIDTH bits.

Structure
REQ-026 SHALL place the FSM state enum and the counter-width helper function in shared package pal_se_pkg.
REQ-027 SHALL implement the block as a single module with no sub-module, because shift register, counter and FSM are tightly coupled.

Verification
REQ-028 SHALL verify: WIDTH=4, MSB_FIRST=1, load 4'b1011 -> out 1,0,1,1 on cycles 1-4, done on cycle 4, IDLE on cycle 5.
REQ-029 SHALL verify: WIDTH=4, load 4'b1011, then load 4'b0101 after two bits -> out 1,0,0,1,0,1, with a single done on the last bit.
REQ-030 SHALL verify: WIDTH=8, MSB_FIRST=0, load 8'hA5 -> out 1,0,1,0,0,1,0,1.
REQ-031 SHALL verify: shift_en=0 for 2 cycles after the second bit of 4'b1011 -> out holds 0 for 3 cycles, then 1,1, and done is delayed by 2 cycles.
REQ-032 SHALL verify: reset asserted on the third bit of a frame -> next cycle out=0, out_valid=0, busy=0, and no done pulse.
REQ-033 SHALL verify, with PAL_SE_PARITY_EN defined: WIDTH=4, load 4'b1011 -> out 1,0,1,1,1 with done on the fifth bit; and load 4'b0101 -> parity bit 0.

Source files
------------

// File: rtl/pal_se_pkg.sv
// rtl/pal_se_pkg.sv - shared FSM states and counter sizing for pal_se_nbits (PAL_SE_PARITY_EN adds PAR)
package pal_se_pkg;

`ifdef PAL_SE_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/pal_se_nbits.sv
// rtl/pal_se_nbits.sv - parallel-to-serial frame shifter; PAL_SE_PARITY_EN appends an even-parity bit
module pal_se_nbits
    import pal_se_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             shift_en,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
`ifdef PAL_SE_PARITY_EN
    logic             par;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    // cnt holds the number of data bits still to show, including the one on out
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            sh        <= '0;
`ifdef PAL_SE_PARITY_EN
            par       <= 1'b0;
`endif
        end else if (load) begin
            state     <= SHIFT;
            out       <= head(in);
            sh        <= advance(in);
            cnt       <= CW'(WIDTH);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
`ifdef PAL_SE_PARITY_EN
            par       <= ^in;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (shift_en) begin
                        if (cnt > CW'(1)) begin
                            out <= head(sh);
                            sh  <= advance(sh);
                            cnt <= cnt - CW'(1);
`ifdef PAL_SE_PARITY_EN
                            done <= 1'b0;
`else
                            done <= (cnt == CW'(2));
`endif
                        end else begin
`ifdef PAL_SE_PARITY_EN
                            state <= PAR;
                            out   <= par;
                            done  <= 1'b1;
                            cnt   <= '0;
`else
                            state     <= IDLE;
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b0;
                            cnt       <= '0;
                            sh        <= '0;
`endif
                        end
                    end
                end
`ifdef PAL_SE_PARITY_EN
                PAR: begin
                    if (shift_en) begin
                        state     <= IDLE;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        sh        <= '0;
                    end
                end
`endif
                default: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pal_se_nbits.sv
// tb/tb_pal_se_nbits.sv - randomized model-checked bench for pal_se_nbits (PAL_SE_PARITY_EN aware)
module tb_pal_se_nbits;

    logic       clk = 1'b0;
    logic       reset, load4, load8, se;
    logic [3:0] in4;
    logic [7:0] in8;
    logic       o4, v4, b4, dn4, o8, v8, b8, dn8;

    always #5 clk = ~clk;

    pal_se_nbits #(.WIDTH(4), .MSB_FIRST(1)) u4 (
        .clk(clk), .reset(reset), .load(load4), .in(in4), .shift_en(se),
        .out(o4), .out_valid(v4), .busy(b4), .done(dn4)
    );

    pal_se_nbits #(.WIDTH(8), .MSB_FIRST(0)) u8 (
        .clk(clk), .reset(reset), .load(load8), .in(in8), .shift_en(se),
        .out(o8), .out_valid(v8), .busy(b8), .done(dn8)
    );

`ifdef PAL_SE_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wid [2] = '{4, 8};
    int          msbf[2] = '{1, 0};
    int          m_act[2];
    int          m_pos[2];
    logic [31:0] m_word[2];
    logic        d_out[2], d_val[2], d_busy[2], d_done[2];
    logic        lg_out[$], lg_done[$], lg_val[$], lg8_out[$];

    assign d_out[0] = o4;  assign d_val[0] = v4;  assign d_busy[0] = b4;  assign d_done[0] = dn4;
    assign d_out[1] = o8;  assign d_val[1] = v8;  assign d_busy[1] = b8;  assign d_done[1] = dn8;

    // Frame bit k: data bits in the chosen order, then parity as bit index WIDTH
    function automatic logic exp_bit(input int d, input int k);
        logic [31:0] w;
        w = m_word[d];
        if (k == wid[d]) return ^w;
        return (msbf[d] != 0) ? w[wid[d] - 1 - k] : w[k];
    endfunction

    function automatic logic [31:0] qvec(input logic q[$]);
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v = (v << 1) | 32'(q[i]);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int d, input logic rst, input logic ld, input logic [31:0] w, input logic s);
        if (rst) m_act[d] = 0;
        else if (ld) begin
            m_act[d] = 1; m_pos[d] = 0; m_word[d] = w;
        end else if (m_act[d] != 0 && s) begin
            if (m_pos[d] == wid[d] + PB - 1) m_act[d] = 0;
            else m_pos[d]++;
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            logic eo, ev, ed;
            eo = (m_act[d] != 0) ? exp_bit(d, m_pos[d]) : 1'b0;
            ev = (m_act[d] != 0);
            ed = (m_act[d] != 0) && (m_pos[d] == wid[d] + PB - 1);
            check($sformatf("u%0d.out", wid[d]), 32'(d_out[d]), 32'(eo));
            check($sformatf("u%0d.out_valid", wid[d]), 32'(d_val[d]), 32'(ev));
            check($sformatf("u%0d.busy", wid[d]), 32'(d_busy[d]), 32'(ev));
            check($sformatf("u%0d.done", wid[d]), 32'(d_done[d]), 32'(ed));
        end
    endtask

    task automatic step(input logic rst, input logic ld4, input logic [3:0] w4,
                        input logic ld8, input logic [7:0] w8, input logic s);
        reset = rst; load4 = ld4; in4 = w4; load8 = ld8; in8 = w8; se = s;
        @(posedge clk);
        model_edge(0, rst, ld4, 32'(w4), s);
        model_edge(1, rst, ld8, 32'(w8), s);
        @(negedge clk);
        compare_all();
        lg_out.push_back(o4); lg_done.push_back(dn4); lg_val.push_back(v4);
        lg8_out.push_back(o8);
    endtask

    task automatic clear_logs();
        lg_out.delete(); lg_done.delete(); lg_val.delete(); lg8_out.delete();
    endtask

    task automatic idle4(input logic s);
        step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, s);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin m_act[d] = 0; m_pos[d] = 0; m_word[d] = '0; end
        step(1'b1, 1'b1, 4'hF, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        check("reset_out", 32'(o4), 32'd0);
        check("reset_valid", 32'({v4, b4, dn4, v8, b8, dn8}), 32'd0);

        // Plain frame 1011, MSB first
        clear_logs();
        step(1'b0, 1'b1, 4'b1011, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) idle4(1'b1);
`ifdef PAL_SE_PARITY_EN
        check("frame_out", qvec(lg_out), 32'b101110);
        check("frame_done", qvec(lg_done), 32'b000010);
`else
        check("frame_out", qvec(lg_out), 32'b101100);
        check("frame_done", qvec(lg_done), 32'b000100);
`endif

        // Restart after two bits with 0101 (parity 0)
        clear_logs();
        step(1'b0, 1'b1, 4'b1011, 1'b0, 8'h00, 1'b1);
        idle4(1'b1);
        step(1'b0, 1'b1, 4'b0101, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) idle4(1'b1);
        check("restart_out", qvec(lg_out), 32'b10010100);
`ifdef PAL_SE_PARITY_EN
        check("restart_done", qvec(lg_done), 32'b00000010);
`else
        check("restart_done", qvec(lg_done), 32'b00000100);
`endif

        // LSB-first 8-bit A5
        clear_logs();
        step(1'b0, 1'b0, 4'h0, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) idle4(1'b1);
`ifdef PAL_SE_PARITY_EN
        check("lsb_out", qvec(lg8_out), 32'b101001010);
`else
        check("lsb_out", qvec(lg8_out), 32'b101001010);
`endif

        // Stall two cycles after the second bit
        clear_logs();
        step(1'b0, 1'b1, 4'b1011, 1'b0, 8'h00, 1'b1);
        idle4(1'b1);
        idle4(1'b0);
        idle4(1'b0);
        for (int i = 0; i < 4; i++) idle4(1'b1);
`ifdef PAL_SE_PARITY_EN
        check("stall_out", qvec(lg_out), 32'b10001110);
        check("stall_done", qvec(lg_done), 32'b00000010);
`else
        check("stall_out", qvec(lg_out), 32'b10001100);
        check("stall_done", qvec(lg_done), 32'b00000100);
`endif

        // Reset on the third bit
        clear_logs();
        step(1'b0, 1'b1, 4'b1011, 1'b0, 8'h00, 1'b1);
        idle4(1'b1);
        idle4(1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        idle4(1'b1);
        check("rst_out", qvec(lg_out), 32'b10100);
        check("rst_valid", qvec(lg_val), 32'b11100);
        check("rst_done", qvec(lg_done), 32'b00000);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 6) == 0, 4'($urandom),
                 $urandom_range(0, 10) == 0, 8'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
